sdram_arbit: RTL and testbench

- Command-bus arbiter and scheduler between the SDRAM init, auto-refresh, write and read sub-controllers inside sdram_top.
- Holds the bus for init until it completes.
- After init, grants the single SDRAM command/address/bank bus to one requester at a time: refresh first, then write/read in round-robin.
- Muxes the granted requester's command onto the bus and runs a watchdog on each grant.

---
 rtl/sdram_pkg.sv | 27 ++
 rtl/sdram_arbit.sv | 138 +++++++++++++
 tb/tb_sdram_arbit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, arbiter states, bus widths.
// No logic of its own.
// Imported by the arbiter and its bench.
package sdram_pkg;

  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam int CMD_W  = 4;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF      = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS       = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ACT       = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WRITE     = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_READ      = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init owns the bus, then refresh > write/read round-robin, with a grant watchdog.
// Latency: req in ARBIT cycle N -> *_en in cycle N+1; bus mux is combinational from the registered state.
// Backpressure: requesters hold req until their *_en; a grant lasts until *_end or MAX_BUSY cycles.
module sdram_arbit #(
  parameter int                          MAX_BUSY = 1024,
  parameter logic [sdram_pkg::CMD_W-1:0] CMD_NOP  = 4'b0111
) (
  input  logic                          sclk,
  input  logic                          reset,
  input  logic                          init_done,
  input  logic [sdram_pkg::CMD_W-1:0]   init_cmd,
  input  logic [sdram_pkg::ADDR_W-1:0]  init_addr,
  input  logic                          aref_req,
  input  logic                          aref_end,
  input  logic [sdram_pkg::CMD_W-1:0]   aref_cmd,
  input  logic [sdram_pkg::ADDR_W-1:0]  aref_addr,
  input  logic                          wr_req,
  input  logic                          wr_end,
  input  logic [sdram_pkg::CMD_W-1:0]   wr_cmd,
  input  logic [sdram_pkg::ADDR_W-1:0]  wr_addr,
  input  logic [sdram_pkg::BANK_W-1:0]  wr_bank,
  input  logic                          rd_req,
  input  logic                          rd_end,
  input  logic [sdram_pkg::CMD_W-1:0]   rd_cmd,
  input  logic [sdram_pkg::ADDR_W-1:0]  rd_addr,
  input  logic [sdram_pkg::BANK_W-1:0]  rd_bank,
  output logic                          aref_en,
  output logic                          wr_en,
  output logic                          rd_en,
  output logic [sdram_pkg::CMD_W-1:0]   sdram_cmd,
  output logic [sdram_pkg::ADDR_W-1:0]  sdram_addr,
  output logic [sdram_pkg::BANK_W-1:0]  sdram_bank,
  output logic                          busy_err,
  output logic [2:0]                    arb_state
);
  import sdram_pkg::*;

  localparam int CNT_W = (MAX_BUSY > 2) ? $clog2(MAX_BUSY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BUSY - 1);

  arb_state_t       state;
  arb_state_t       last_grant;
  logic [CNT_W-1:0] busy_cnt;
  logic             grant_end;
  logic             wr_wins;

  // Only the current grantee's end pulse counts; the one-hot *_en doubles as the grantee select.
  assign grant_end = (aref_en & aref_end) | (wr_en & wr_end) | (rd_en & rd_end);

  // Write takes a tie unless it was the last one served.
  assign wr_wins = wr_req && (!rd_req || (last_grant != ST_WRITE));

  assign arb_state = state;

  // Scheduler FSM with registered grants, round-robin memory and watchdog.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= ST_READ;
      busy_cnt   <= '0;
      aref_en    <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      busy_err   <= 1'b0;
    end else begin
      busy_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_done) state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          busy_cnt <= '0;
          if (aref_req) begin
            state   <= ST_AREF;
            aref_en <= 1'b1;
          end else if (wr_wins) begin
            state <= ST_WRITE;
            wr_en <= 1'b1;
          end else if (rd_req) begin
            state <= ST_READ;
            rd_en <= 1'b1;
          end
        end
        ST_AREF, ST_WRITE, ST_READ: begin
          if (grant_end || (busy_cnt == CNT_LAST)) begin
            // Normal end and watchdog timeout release the bus the same way.
            busy_err <= !grant_end;
            state    <= ST_ARBIT;
            aref_en  <= 1'b0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            if (state == ST_WRITE) last_grant <= ST_WRITE;
            if (state == ST_READ)  last_grant <= ST_READ;
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          aref_en <= 1'b0;
          wr_en   <= 1'b0;
          rd_en   <= 1'b0;
        end
      endcase
    end
  end

  // Bus mux from the registered state; reset forces NOP so the bus idles immediately.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          sdram_cmd  = init_cmd;
          sdram_addr = init_addr;
        end
        ST_AREF: begin
          sdram_cmd  = aref_cmd;
          sdram_addr = aref_addr;
        end
        ST_WRITE: begin
          sdram_cmd  = wr_cmd;
          sdram_addr = wr_addr;
          sdram_bank = wr_bank;
        end
        ST_READ: begin
          sdram_cmd  = rd_cmd;
          sdram_addr = rd_addr;
          sdram_bank = rd_bank;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit with a shortened watchdog.
// Inputs change 2 time units after the rising edge; outputs are sampled there too.
// Ends with a single summary line.
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done = 1'b0;
  logic [3:0]  init_cmd = 4'b0010;
  logic [11:0] init_addr = 12'h400;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0001;
  logic [11:0] aref_addr = 12'h155;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [11:0] wr_addr = 12'h0A5;
  logic [1:0]  wr_bank = 2'd2;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [11:0] rd_addr = 12'h3C3;
  logic [1:0]  rd_bank = 2'd1;
  logic        aref_en, wr_en, rd_en, busy_err;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [2:0]  arb_state;

  int n_checks = 0;
  int n_errors = 0;

  sdram_arbit #(.MAX_BUSY(16), .CMD_NOP(4'b0111)) dut (
    .sclk(sclk), .reset(reset), .init_done(init_done),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .busy_err(busy_err), .arb_state(arb_state)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  hi;
    bit  done;

    // Reset values, with reset still asserted
    #3;
    chk("rst_state", arb_state, 0);
    chk("rst_cmd", sdram_cmd, 4'b0111);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_ens", {aref_en, wr_en, rd_en, busy_err}, 4'b0000);
    tick();
    reset = 1'b0;
    #1;
    chk("idle_cmd", sdram_cmd, 4'b0010);
    chk("idle_addr", sdram_addr, 12'h400);
    chk("idle_bank", sdram_bank, 0);

    // Wait in IDLE without init_done, then release
    repeat (8) tick();
    chk("idle_hold", arb_state, 0);
    init_done = 1'b1;
    tick();
    chk("to_arbit", arb_state, 1);
    chk("arbit_cmd", sdram_cmd, 4'b0111);
    chk("arbit_addr", sdram_addr, 0);
    init_done = 1'b0;
    tick();
    chk("init_drop_ignored", arb_state, 1);

    // All three requests together: refresh wins
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    tick();
    chk("pri_aref_en", aref_en, 1);
    chk("pri_wr_rd_en", {wr_en, rd_en}, 2'b00);
    chk("aref_bus_cmd", sdram_cmd, 4'b0001);
    chk("aref_bus_addr", sdram_addr, 12'h155);
    chk("aref_bus_bank", sdram_bank, 0);
    aref_req = 1'b0;
    tick(); tick();
    aref_end = 1'b1;
    tick();
    aref_end = 1'b0;
    chk("aref_exit_state", arb_state, 1);
    chk("aref_exit_en", aref_en, 0);
    tick();
    chk("tie_wr_first", wr_en, 1);
    chk("tie_rd_low", rd_en, 0);
    chk("wr_bus_cmd", sdram_cmd, 4'b0100);
    chk("wr_bus_addr", sdram_addr, 12'h0A5);
    chk("wr_bus_bank", sdram_bank, 2);

    // Foreign end pulse is ignored
    rd_end = 1'b1;
    tick();
    rd_end = 1'b0;
    chk("foreign_end_wr_en", wr_en, 1);
    chk("foreign_end_state", arb_state, 3);
    wr_req = 1'b0;
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    chk("wr_exit_state", arb_state, 1);
    chk("wr_exit_en", wr_en, 0);
    tick();
    chk("after_wr_rd_en", rd_en, 1);
    chk("rd_bus_cmd", sdram_cmd, 4'b0101);
    chk("rd_bus_addr", sdram_addr, 12'h3C3);
    chk("rd_bus_bank", sdram_bank, 1);
    rd_req = 1'b0;

    // Watchdog: no rd_end, grant must end after 16 cycles
    hi = 1;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (rd_en) hi++;
      else begin
        done = 1'b1;
        chk("wd_err_pulse", busy_err, 1);
        chk("wd_state", arb_state, 1);
      end
    end
    chk("wd_released", done, 1);
    chk("wd_len", hi, 16);
    tick();
    chk("wd_err_one_cycle", busy_err, 0);

    // Continuous wr/rd: alternate starting with write (last was read)
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 8; g++) begin
      tick();
      if (g % 2 == 0) chk("alt_grant_w", {wr_en, rd_en}, 2'b10);
      else            chk("alt_grant_r", {wr_en, rd_en}, 2'b01);
      tick(); tick();
      if (g % 2 == 0) wr_end = 1'b1;
      else            rd_end = 1'b1;
      tick();
      wr_end = 1'b0; rd_end = 1'b0;
      chk("alt_back_arbit", arb_state, 1);
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // Reset two cycles into a refresh grant
    aref_req = 1'b1;
    tick();
    aref_req = 1'b0;
    chk("aref2_en", aref_en, 1);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_aref_en", aref_en, 0);
    chk("midrst_cmd", sdram_cmd, 4'b0111);
    chk("midrst_state", arb_state, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_idle", arb_state, 0);
    chk("post_rst_bus", sdram_cmd, 4'b0010);
    init_done = 1'b1;
    tick();
    chk("post_rst_arbit", arb_state, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
